// File: rtl/uart_line_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_line_rx
//  Description : Parametrised UART receiver with CR/LF line assembly.
//                Deserialises an asynchronous serial line (DATA_BITS data
//                bits, optional odd/even parity, one stop bit, LSB first)
//                into bytes. Good bytes are collected into lines terminated
//                by CR or LF. The last LINE_BYTES bytes of every completed
//                line are presented, newest byte in the low 8 bits.
//  Ports       : clk        - system clock, rising edge
//                rst        - asynchronous reset, active high
//                rx         - raw serial input, idle high, async to clk
//                byte_data  - last received data word
//                byte_valid - 1-cycle pulse, byte_data/parity_err updated
//                parity_err - parity mismatch on the byte of byte_valid
//                frame_err  - 1-cycle pulse, stop bit low, byte discarded
//                line_data  - last LINE_BYTES bytes of the completed line
//                line_len   - bytes in the line, saturating at LINE_BYTES
//                line_valid - 1-cycle pulse, line_data/line_len updated
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_line_rx #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int LINE_BYTES = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rx,
    output logic [DATA_BITS-1:0]               byte_data,
    output logic                               byte_valid,
    output logic                               parity_err,
    output logic                               frame_err,
    output logic [8*LINE_BYTES-1:0]            line_data,
    output logic [$clog2(LINE_BYTES+1)-1:0]    line_len,
    output logic                               line_valid
);

    // CLKS_PER_BIT must be at least 8 for the mid-bit sampling to be sound.
    localparam int C_CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int C_HALF_BIT     = C_CLKS_PER_BIT / 2;
    localparam int C_CNT_W        = $clog2(C_CLKS_PER_BIT);
    localparam int C_BIT_W        = $clog2(DATA_BITS + 1);
    localparam int C_LINE_W       = 8 * LINE_BYTES;
    localparam int C_LEN_W        = $clog2(LINE_BYTES + 1);

    localparam logic [C_CNT_W-1:0] C_CNT_LAST  = C_CNT_W'(C_CLKS_PER_BIT - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_HALF  = C_CNT_W'(C_HALF_BIT);
    // Consecutive high samples needed in WAIT_IDLE: covers the synchroniser
    // depth, whose reset value is "idle high" and therefore not evidence of
    // a real idle line.
    localparam logic [C_CNT_W-1:0] C_CNT_FLUSH = C_CNT_W'(2);
    localparam logic [C_BIT_W-1:0] C_BIT_LAST  = C_BIT_W'(DATA_BITS - 1);
    localparam logic [C_LEN_W-1:0] C_LEN_MAX   = C_LEN_W'(LINE_BYTES);

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_IDLE      = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_PARITY    = 3'd4,
        S_STOP      = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_BIT_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 w_cnt_clear;
    logic                 w_shift_en;
    logic                 w_par_en;
    logic                 w_byte_done;
    logic                 w_frame_fail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_WAIT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_clear  = 1'b0;
        w_shift_en   = 1'b0;
        w_par_en     = 1'b0;
        w_byte_done  = 1'b0;
        w_frame_fail = 1'b0;
        case (r_state)
            S_WAIT_IDLE: begin
                // Counter tracks consecutive high samples here.
                if (!r_rx_sync) begin
                    w_cnt_clear = 1'b1;
                end else if (r_cnt == C_CNT_FLUSH) begin
                    w_cnt_clear  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                w_cnt_clear = 1'b1;
                if (!r_rx_sync) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (r_cnt == C_CNT_HALF) begin
                    w_cnt_clear  = 1'b1;
                    // A start bit that is high again at mid-bit was a glitch.
                    w_state_next = r_rx_sync ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_clear = 1'b1;
                    w_shift_en  = 1'b1;
                    if (r_bit_idx == C_BIT_LAST) begin
                        w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_clear  = 1'b1;
                    w_par_en     = 1'b1;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_clear = 1'b1;
                    if (r_rx_sync) begin
                        // Going straight to IDLE re-arms for a start bit that
                        // may follow only half a bit later.
                        w_byte_done  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        // Break or stuck-low line: wait for a genuine idle.
                        w_frame_fail = 1'b1;
                        w_state_next = S_WAIT_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
        end else begin
            if (w_cnt_clear) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state != S_DATA) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            // LSB arrives first, so shift towards bit 0.
            if (w_shift_en) begin
                r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
            end

            if (r_state == S_IDLE) begin
                r_perr <= 1'b0;
            end else if (w_par_en) begin
                r_perr <= (((^r_shift) ^ r_rx_sync) != (PARITY == 1));
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte outputs
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_byte_data;
    logic                 r_byte_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= w_byte_done;
            r_frame_err  <= w_frame_fail;
            if (w_byte_done) begin
                r_byte_data  <= r_shift;
                r_parity_err <= r_perr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line assembly
    // ------------------------------------------------------------------
    logic [7:0]          w_byte8;
    logic                w_is_term;
    logic [C_LINE_W-1:0] w_acc_shifted;
    logic [C_LINE_W-1:0] r_acc;
    logic [C_LEN_W-1:0]  r_count;
    logic                r_term_seen;
    logic [C_LINE_W-1:0] r_line_data;
    logic [C_LEN_W-1:0]  r_line_len;
    logic                r_line_valid;

    always_comb begin
        w_byte8                  = '0;
        w_byte8[DATA_BITS-1:0]   = r_byte_data;
        w_is_term                = (w_byte8 == 8'h0D) || (w_byte8 == 8'h0A);
        // Oldest byte falls off the top when the line is longer than kept.
        w_acc_shifted            = (r_acc << 8) | C_LINE_W'(w_byte8);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_term_seen  <= 1'b0;
            r_line_data  <= '0;
            r_line_len   <= '0;
            r_line_valid <= 1'b0;
        end else begin
            r_line_valid <= 1'b0;
            if (r_byte_valid && !r_parity_err) begin
                if (!w_is_term) begin
                    r_acc       <= w_acc_shifted;
                    r_term_seen <= 1'b0;
                    if (r_count != C_LEN_MAX) begin
                        r_count <= r_count + 1'b1;
                    end
                end else if (!r_term_seen) begin
                    r_line_data  <= r_acc;
                    r_line_len   <= r_count;
                    r_line_valid <= 1'b1;
                    r_acc        <= '0;
                    r_count      <= '0;
                    r_term_seen  <= 1'b1;
                end else begin
                    // Second half of a CRLF / LFCR pair.
                    r_term_seen <= 1'b0;
                end
            end
        end
    end

    assign byte_data  = r_byte_data;
    assign byte_valid = r_byte_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign line_data  = r_line_data;
    assign line_len   = r_line_len;
    assign line_valid = r_line_valid;

endmodule
`default_nettype wire
